// File: rtl/el_pkg.sv
// Shared types and constants for the elastic link transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package el_pkg;

  // Transmitter control states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Rail offsets within a dual-rail link: out[2i+RAIL0] carries 0, out[2i+RAIL1] carries 1
  localparam int RAIL0 = 0;
  localparam int RAIL1 = 1;

  // Default depth of each ack synchronizer
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/el_ack_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous two-phase ack level.
// Latency: STAGES clock edges from input change to q change.
// Backpressure: none; free-running shift chain.
module el_ack_sync #(
  parameter int STAGES = el_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level through the chain; all stages clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/el_sync_tx.sv
// Clocked valid/ready to dual-rail two-phase transmitter, one token per link per word.
// Latency: rails toggle at the accept edge; in_ready returns SYNC_STAGES+1 edges after the last ack is captured.
// Backpressure: in_ready stays low from accept until every link has acknowledged its token.
module el_sync_tx
  import el_pkg::*;
#(
  parameter int LINK_NUM    = 3,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LINK_NUM-1:0]   in_data,
  output logic [2*LINK_NUM-1:0] out,
  input  logic [LINK_NUM-1:0]   ack_i,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  proto_err
);

  // Counter just wide enough to hold TIMEOUT-1, where it saturates
  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT - 2);

  state_t                state;
  state_t                state_nxt;
  logic [LINK_NUM-1:0]   ack_s;
  logic [LINK_NUM-1:0]   ack_ref;
  logic [LINK_NUM-1:0]   ack_edge;
  logic [LINK_NUM-1:0]   done;
  logic [2*LINK_NUM-1:0] out_q;
  logic [2*LINK_NUM-1:0] tmask;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  in_wait;

  // One synchronizer per incoming ack level
  for (genvar g = 0; g < LINK_NUM; g++) begin : g_sync
    el_ack_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_i[g]),
      .q   (ack_s[g])
    );
  end

  assign in_wait  = (state == ST_WAIT);
  assign in_ready = (state == ST_IDLE);
  assign busy     = in_wait;
  assign accept   = in_valid && (state == ST_IDLE);
  assign ack_edge = ack_s ^ ack_ref;
  assign out      = out_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave WAIT only once every registered done flag is set
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_WAIT;
      ST_WAIT: if (&done)    state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Select exactly one rail per link according to the data bit
  always_comb begin
    tmask = '0;
    for (int i = 0; i < LINK_NUM; i++) begin
      if (in_data[i]) begin
        tmask[2*i + RAIL1] = 1'b1;
      end else begin
        tmask[2*i + RAIL0] = 1'b1;
      end
    end
  end

  // Rail levels: toggled on accept, cleared by reset (aborts an in-flight token)
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (accept) begin
      out_q <= out_q ^ tmask;
    end
  end

  // Every observed edge is consumed, so the reference simply follows the synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_ref <= '0;
    end else begin
      ack_ref <= ack_s;
    end
  end

  // Per-link completion flags for the word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= '0;
    end else if (accept) begin
      done <= '0;
    end else if (in_wait) begin
      done <= done | ack_edge;
    end
  end

  // WAIT cycle counter, saturating at TIMEOUT-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (in_wait && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky error flags; the timeout flag rises on the edge the counter reaches TIMEOUT-1
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (in_wait && (cnt == CNT_PRE)) begin
        timeout_err <= 1'b1;
      end
      if ((in_wait && |(ack_edge & done)) || (!in_wait && |ack_edge)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_el_sync_tx.sv
// Directed self-checking bench for el_sync_tx.
// Latency: n/a.
// Backpressure: n/a.
module tb_el_sync_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, busy, timeout_err, proto_err;
  logic [2:0] in_data, ack;
  logic [5:0] out;

  logic       in_valid_t, in_ready_t, busy_t, timeout_err_t, proto_err_t;
  logic [2:0] in_data_t, ack_t;
  logic [5:0] out_t;

  int nvec = 0;
  int nerr = 0;
  int n;

  logic [2:0] words [5] = '{3'b101, 3'b000, 3'b111, 3'b011, 3'b111};
  logic [5:0] exp_o [5] = '{6'b011001, 6'b001100, 6'b100110, 6'b111100, 6'b010110};

  always #5 clk = ~clk;

  el_sync_tx #(.LINK_NUM(3), .SYNC_STAGES(2), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out(out), .ack_i(ack), .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  el_sync_tx #(.LINK_NUM(3), .SYNC_STAGES(2), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid_t), .in_ready(in_ready_t), .in_data(in_data_t),
    .out(out_t), .ack_i(ack_t), .busy(busy_t), .timeout_err(timeout_err_t), .proto_err(proto_err_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ack = '0;
    in_valid_t = 1'b0; in_data_t = '0; ack_t = '0;
    repeat (5) step();
    chk("rst_out", out, 6'b000000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_proto", proto_err, 1'b0);
    rst = 1'b0;
    step();

    // Single word 101
    in_valid = 1'b1; in_data = 3'b101;
    step();
    in_valid = 1'b0; in_data = 3'b000;
    chk("w101_out", out, 6'b100110);
    chk("w101_in_ready", in_ready, 1'b0);
    chk("w101_busy", busy, 1'b1);
    ack = 3'b111;
    wait_ready(n);
    chk("w101_ack_latency", n, 4);
    chk("w101_busy_done", busy, 1'b0);

    // Staggered acks on word 010: links 0, 2, then 1
    in_valid = 1'b1; in_data = 3'b010;
    step();
    in_valid = 1'b0;
    chk("w010_out", out, 6'b111111);
    ack[0] = ~ack[0];
    repeat (20) step();
    chk("stag_busy_after_l0", busy, 1'b1);
    ack[2] = ~ack[2];
    repeat (20) step();
    chk("stag_busy_after_l2", busy, 1'b1);
    ack[1] = ~ack[1];
    wait_ready(n);
    chk("stag_latency", n, 4);
    chk("stag_proto", proto_err, 1'b0);
    chk("stag_timeout", timeout_err, 1'b0);

    // Back-to-back words with immediate acks: 5-cycle period
    for (int w = 0; w < 5; w++) begin
      in_valid = 1'b1; in_data = words[w];
      step();
      in_valid = 1'b0;
      chk($sformatf("b2b%0d_out", w), out, exp_o[w]);
      ack = ack ^ 3'b111;
      wait_ready(n);
      chk($sformatf("b2b%0d_period", w), n + 1, 5);
    end
    chk("b2b_proto", proto_err, 1'b0);

    // Spurious ack on link 1 while idle
    ack[1] = ~ack[1];
    step();
    step();
    chk("spur_proto_early", proto_err, 1'b0);
    step();
    chk("spur_proto", proto_err, 1'b1);
    chk("spur_out_unchanged", out, 6'b010110);
    in_valid = 1'b1; in_data = 3'b000;
    step();
    in_valid = 1'b0;
    chk("spur_word_out", out, 6'b000011);
    ack = ack ^ 3'b111;
    wait_ready(n);
    chk("spur_word_latency", n, 4);

    // Reset clears the sticky flag; ack levels return to 0 together
    rst = 1'b1; ack = '0;
    repeat (5) step();
    chk("rst2_proto", proto_err, 1'b0);
    chk("rst2_out", out, 6'b000000);
    rst = 1'b0;
    step();

    // Double ack on link 0 within one word
    in_valid = 1'b1; in_data = 3'b110;
    step();
    in_valid = 1'b0;
    chk("dbl_out", out, 6'b101001);
    ack[0] = ~ack[0];
    repeat (5) step();
    chk("dbl_proto_first", proto_err, 1'b0);
    ack[0] = ~ack[0];
    repeat (5) step();
    chk("dbl_proto", proto_err, 1'b1);
    chk("dbl_busy", busy, 1'b1);
    ack = ack ^ 3'b110;
    wait_ready(n);
    chk("dbl_latency", n, 4);
    chk("dbl_busy_done", busy, 1'b0);
    chk("dbl_timeout", timeout_err, 1'b0);

    // Timeout with withheld acks, then reset mid-operation (TIMEOUT=16 instance)
    in_valid_t = 1'b1; in_data_t = 3'b111;
    step();
    in_valid_t = 1'b0;
    chk("to_out", out_t, 6'b101010);
    repeat (14) step();
    chk("to_before", timeout_err_t, 1'b0);
    step();
    chk("to_at_15", timeout_err_t, 1'b1);
    chk("to_busy", busy_t, 1'b1);
    repeat (5) step();
    chk("to_still_wait", busy_t, 1'b1);
    chk("to_in_ready", in_ready_t, 1'b0);
    chk("to_proto", proto_err_t, 1'b0);
    rst = 1'b1;
    step();
    chk("to_rst_out", out_t, 6'b000000);
    chk("to_rst_in_ready", in_ready_t, 1'b1);
    chk("to_rst_timeout", timeout_err_t, 1'b0);
    chk("to_rst_busy", busy_t, 1'b0);
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
